ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; the send side of the keyboard link the Enigma front end already receives on.

---
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
// Sends one command byte to a PS/2 device and checks the device ACK.
// Both bus lines are driven open-drain through low-enables; the pad wrapper
// is expected to tie pad = oe ? 1'b0 : 1'bz.
//
// Ports
//   clock       in   system clock
//   resetn      in   asynchronous active-low reset
//   tx_data     in   byte to send
//   tx_valid    in   request, accepted when tx_valid && tx_ready
//   tx_ready    out  high only while idle
//   busy        out  high whenever not idle
//   done        out  1-cycle pulse: device ACKed and bus returned idle
//   error       out  1-cycle pulse: timeout or NACK, transfer abandoned
//   ps2_clk_in  in   raw PS2_CLK pad level (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT pad level (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_BITS, S_ACK, S_WAIT_IDLE
  } state_e;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_idx_q, bit_idx_d;   // device falls seen in S_BITS
  logic [10:0]       sh_q, sh_d;             // {stop, parity, data, start}, bit 0 on the wire
  logic [1:0]        clk_sync_q, dat_sync_q;
  logic              clk_prev_q;

  logic clk_s, dat_s, fall, tmo_hit, bus_idle, dev_state;

  assign clk_s     = clk_sync_q[1];
  assign dat_s     = dat_sync_q[1];
  assign fall      = clk_prev_q & ~clk_s;
  assign tmo_hit   = (cnt_q == TMO_LAST);
  assign bus_idle  = clk_s & dat_s;
  assign dev_state = (state_q == S_BITS) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

  // Synchronisers reset to 1 (idle bus level) so reset release never fakes a fall.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      clk_prev_q <= clk_s;
    end
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          sh_d    = {1'b1, ~^tx_data, tx_data, 1'b0};
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = S_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BITS: begin
        if (fall) begin
          cnt_d     = '0;
          sh_d      = {1'b1, sh_q[10:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          // tenth fall puts the stop bit (released line) on the wire
          if (bit_idx_q == 4'd9) state_d = S_ACK;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = dat_s ? S_IDLE : S_WAIT_IDLE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        // bus idle wins over a coincident timeout so done/error never overlap
        if (bus_idle) begin
          state_d = S_IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_ready   = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    ps2_clk_oe = (state_q == S_INHIBIT);
    ps2_dat_oe = (state_q == S_BITS) && !sh_q[0];
    done       = (state_q == S_WAIT_IDLE) && bus_idle;
    error      = ((state_q == S_ACK) && fall && dat_s) ||
                 (dev_state && !fall && tmo_hit &&
                  !((state_q == S_WAIT_IDLE) && bus_idle));
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard of expected outcomes/frames is checked by a separate monitor.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 200;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  // wired-AND open-drain bus
  assign ps2_clk_in = ps2_clk_oe ? 1'b0 : dev_clk;
  assign ps2_dat_in = ps2_dat_oe ? 1'b0 : dev_dat;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
    .clock(clock), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    bit         is_err;
    bit         chk_frame;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          pulse_cnt = 0;
  int          last_done_cyc = -10;
  logic [10:0] cap_frame = '0;
  int          dev_mode = 0;   // 0 normal ACK, 1 never clocks, 2 NACK
  int          dev_falls = 0;
  bit          dev_abort = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done && error) chk("done_and_error", 32'd1, 32'd0);
      if (done || error) begin
        pulse_cnt++;
        if (done) last_done_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, done, error}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("outcome_is_error", {31'd0, error}, {31'd0, e.is_err});
          if (e.chk_frame) chk("frame", {21'd0, cap_frame}, {21'd0, ref_frame(e.b)});
        end
      end
    end
  end

  // ---------------- device model ----------------
  task automatic dwait(input int n);
    repeat (n) begin
      @(negedge clock);
      if (!resetn) dev_abort = 1;
    end
  endtask

  task automatic run_frame();
    logic [10:0] f;
    f = '0;
    dev_abort = 0;
    dev_falls = 0;
    f[0] = ps2_dat_in;
    if (dev_mode == 1) return;
    for (int i = 1; i <= 10; i++) begin
      dwait(20);
      if (dev_abort) break;
      dev_clk = 1'b0;
      dev_falls = i;
      dwait(20);
      if (dev_abort) break;
      f[i] = ps2_dat_in;
      dev_clk = 1'b1;
    end
    if (!dev_abort) begin
      cap_frame = f;
      dwait(10);
      if (dev_mode != 2) dev_dat = 1'b0;
      dwait(10);
      dev_clk = 1'b0;
      dwait(20);
      dev_clk = 1'b1;
      dwait(5);
    end
    dev_clk = 1'b1;
    dev_dat = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (ps2_clk_oe) begin
        while (ps2_clk_oe) @(negedge clock);
        if (resetn) run_frame();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input bit is_err, input bit chkf, input bit push);
    int n;
    exp_t e;
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!tx_ready) chk("accept_wait_expired", 32'd0, 32'd1);
    @(negedge clock);
    tx_valid = 1'b0;
    if (push) begin
      e.b = b; e.is_err = is_err; e.chk_frame = chkf;
      sb.push_back(e);
    end
  endtask

  task automatic wait_pulse(input int budget);
    int p0, n;
    p0 = pulse_cnt;
    n = 0;
    while (pulse_cnt == p0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (pulse_cnt == p0) chk("pulse_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    exp_t e;
    // reset state
    repeat (3) @(negedge clock);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_error", {30'd0, done, error}, 32'd0);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // 1: 0xED, inhibit length and start bit
    dev_mode = 0;
    send(8'hED, 0, 1, 1);
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("inhibit_len", n, INH);
    chk("start_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
    wait_pulse(1000);
    @(negedge clock);
    chk("ready_after_done", {31'd0, tx_ready}, 32'd1);

    // 2: parity corner bytes
    send(8'h01, 0, 1, 1);
    wait_pulse(1000);
    chk("parity_01", {31'd0, cap_frame[9]}, 32'd0);
    send(8'h00, 0, 1, 1);
    wait_pulse(1000);
    chk("parity_00", {31'd0, cap_frame[9]}, 32'd1);

    // 3: device never clocks -> timeout
    dev_mode = 1;
    send(8'hA5, 1, 0, 1);
    n = 0;
    while (!ps2_dat_oe && n < 100) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (!error && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_len", n, TMO - 1);
    @(negedge clock);
    chk("timeout_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("timeout_idle", {31'd0, tx_ready}, 32'd1);
    repeat (5) @(negedge clock);

    // 4: NACK
    dev_mode = 2;
    send(8'h3C, 1, 1, 1);
    wait_pulse(1000);
    @(negedge clock);
    chk("nack_idle", {30'd0, tx_ready, busy}, 32'd2);
    dev_mode = 0;
    repeat (60) @(negedge clock);

    // 5: reset mid-frame (0x0F puts a 0 on the wire after fall 5)
    send(8'h0F, 0, 0, 0);
    n = 0;
    while (dev_falls != 5 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    repeat (5) @(negedge clock);
    chk("pre_reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk("reset_oe_immediate", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("post_reset_ready", {30'd0, tx_ready, busy}, 32'd2);
    repeat (60) @(negedge clock);
    send(8'hFF, 0, 1, 1);
    wait_pulse(1000);

    // 6: back-to-back request held high
    @(negedge clock);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    e.b = 8'hED; e.is_err = 0; e.chk_frame = 1;
    sb.push_back(e);
    tx_data = 8'hF4;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("b2b_ready_after_done", cyc - last_done_cyc, 32'd1);
    e.b = 8'hF4; e.is_err = 0; e.chk_frame = 1;
    sb.push_back(e);
    @(negedge clock);
    tx_valid = 1'b0;
    chk("b2b_second_accept", {31'd0, busy}, 32'd1);
    wait_pulse(1000);

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      int m;
      b = 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 2 : 0;
      repeat (60) @(negedge clock);
      dev_mode = m;
      send(b, m == 2, 1, 1);
      wait_pulse(1500);
    end

    repeat (80) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
